// File: rtl/hilo_wb_arb.sv
// Arbitrates the multiplier result FIFO and the one-entry divider holding register
// onto the shared hilo PRF write / ROB completion port, with a starvation guard for the divider.
`ifndef LG_ROB_ENTRIES
`define LG_ROB_ENTRIES 5
`endif
`ifndef LG_HILO_PRF_ENTRIES
`define LG_HILO_PRF_ENTRIES 3
`endif

module hilo_wb_arb #(
    parameter int MUL_DEPTH    = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            mul_issue,
    input  logic                            mul_complete,
    input  logic [63:0]                     mul_y,
    input  logic [`LG_ROB_ENTRIES-1:0]      mul_rob_ptr,
    input  logic                            mul_hilo_val,
    input  logic [`LG_HILO_PRF_ENTRIES-1:0] mul_hilo_ptr,
    input  logic                            div_complete,
    input  logic [63:0]                     div_y,
    input  logic [`LG_ROB_ENTRIES-1:0]      div_rob_ptr,
    input  logic [`LG_HILO_PRF_ENTRIES-1:0] div_hilo_ptr,
    output logic                            div_ready,
    output logic                            mul_can_issue,
    output logic                            wb_valid,
    input  logic                            wb_ready,
    output logic [63:0]                     wb_y,
    output logic [`LG_ROB_ENTRIES-1:0]      wb_rob_ptr,
    output logic                            wb_hilo_val,
    output logic [`LG_HILO_PRF_ENTRIES-1:0] wb_hilo_ptr,
    output logic                            wb_src,
    output logic                            err
);
    localparam int RW = `LG_ROB_ENTRIES;
    localparam int HW = `LG_HILO_PRF_ENTRIES;
    localparam int PW = 64 + RW + 1 + HW;
    localparam int AW = (MUL_DEPTH > 1) ? $clog2(MUL_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [PW-1:0] fifo_mem [MUL_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] occ, inflight;
    logic [SW-1:0] starve;
    logic          div_v, err_q;
    logic [63:0]   div_y_q;
    logic [RW-1:0] div_rob_q;
    logic [HW-1:0] div_hptr_q;

    logic [63:0]   head_y;
    logic [RW-1:0] head_rob;
    logic          head_hval;
    logic [HW-1:0] head_hptr;

    logic fifo_ne, fifo_full, sel_fifo, deq, fifo_deq, div_deq;
    logic mul_enq, mul_drop, div_cap, div_drop;

    assign {head_y, head_rob, head_hval, head_hptr} = fifo_mem[rd_ptr];

    assign fifo_ne   = (occ != '0);
    assign fifo_full = (occ == CW'(MUL_DEPTH));
    // Divider wins once it has lost STARVE_LIMIT arbitrations; starve>0 already implies div_v.
    assign sel_fifo  = fifo_ne && (!div_v || (starve < SW'(STARVE_LIMIT)));
    assign wb_valid  = fifo_ne | div_v;
    assign deq       = wb_valid & wb_ready;
    assign fifo_deq  = deq & sel_fifo;
    assign div_deq   = deq & ~sel_fifo;

    // A full FIFO still takes a new result when its head leaves in the same cycle.
    assign mul_enq   = mul_complete & (~fifo_full | fifo_deq);
    assign mul_drop  = mul_complete & ~mul_enq;
    assign div_cap   = div_complete & (~div_v | div_deq);
    assign div_drop  = div_complete & ~div_cap;

    assign wb_y        = sel_fifo ? head_y    : div_y_q;
    assign wb_rob_ptr  = sel_fifo ? head_rob  : div_rob_q;
    assign wb_hilo_val = sel_fifo ? head_hval : 1'b1;
    assign wb_hilo_ptr = sel_fifo ? head_hptr : div_hptr_q;
    assign wb_src      = ~sel_fifo;

    assign div_ready     = ~div_v;
    assign err           = err_q;
    assign mul_can_issue = ({1'b0, occ} + {1'b0, inflight}) < (CW + 1)'(MUL_DEPTH);

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            occ      <= '0;
            inflight <= '0;
            starve   <= '0;
            div_v    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (fifo_deq) rd_ptr <= rd_ptr + 1'b1;
            if (mul_enq)  wr_ptr <= wr_ptr + 1'b1;
            occ <= occ + CW'(mul_enq) - CW'(fifo_deq);

            // Counter saturates at both ends so a stray completion cannot wrap the credit.
            if (mul_issue && !mul_complete && (inflight != '1))
                inflight <= inflight + 1'b1;
            else if (mul_complete && !mul_issue && (inflight != '0))
                inflight <= inflight - 1'b1;

            if (div_deq)
                starve <= '0;
            else if (div_v && fifo_deq && (starve != SW'(STARVE_LIMIT)))
                starve <= starve + 1'b1;

            if (div_cap)
                div_v <= 1'b1;
            else if (div_deq)
                div_v <= 1'b0;

            if (mul_drop || div_drop)
                err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mul_enq)
            fifo_mem[wr_ptr] <= {mul_y, mul_rob_ptr, mul_hilo_val, mul_hilo_ptr};
        if (div_cap) begin
            div_y_q    <= div_y;
            div_rob_q  <= div_rob_ptr;
            div_hptr_q <= div_hilo_ptr;
        end
    end
endmodule

// File: tb/tb_hilo_wb_arb.sv
// Directed and random stimulus for hilo_wb_arb against a queue-based reference of the
// mul FIFO, div holding register, starvation counter and credit counter.
`ifndef LG_ROB_ENTRIES
`define LG_ROB_ENTRIES 5
`endif
`ifndef LG_HILO_PRF_ENTRIES
`define LG_HILO_PRF_ENTRIES 3
`endif

module tb_hilo_wb_arb;
    localparam int D  = 4;
    localparam int SL = 8;
    localparam int RW = `LG_ROB_ENTRIES;
    localparam int HW = `LG_HILO_PRF_ENTRIES;
    localparam int PW = 64 + RW + 1 + HW;

    logic          clk = 1'b0;
    logic          reset, mul_issue, mul_complete, mul_hilo_val, div_complete, wb_ready;
    logic [63:0]   mul_y, div_y;
    logic [RW-1:0] mul_rob_ptr, div_rob_ptr;
    logic [HW-1:0] mul_hilo_ptr, div_hilo_ptr;
    logic          div_ready, mul_can_issue, wb_valid, wb_hilo_val, wb_src, err;
    logic [63:0]   wb_y;
    logic [RW-1:0] wb_rob_ptr;
    logic [HW-1:0] wb_hilo_ptr;

    int vectors = 0;
    int miscompares = 0;

    // Reference state
    logic [PW-1:0] mq[$];
    logic [PW-1:0] m_div;
    bit            m_dv;
    int            m_starve, m_infl;
    bit            m_err;

    hilo_wb_arb #(.MUL_DEPTH(D), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .reset(reset),
        .mul_issue(mul_issue), .mul_complete(mul_complete), .mul_y(mul_y),
        .mul_rob_ptr(mul_rob_ptr), .mul_hilo_val(mul_hilo_val), .mul_hilo_ptr(mul_hilo_ptr),
        .div_complete(div_complete), .div_y(div_y), .div_rob_ptr(div_rob_ptr),
        .div_hilo_ptr(div_hilo_ptr), .div_ready(div_ready), .mul_can_issue(mul_can_issue),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_y(wb_y), .wb_rob_ptr(wb_rob_ptr),
        .wb_hilo_val(wb_hilo_val), .wb_hilo_ptr(wb_hilo_ptr), .wb_src(wb_src), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        bit ne, sf;
        logic [PW-1:0] e;
        ne = (mq.size() > 0);
        sf = ne && (!m_dv || m_starve < SL);
        e  = sf ? mq[0] : m_div;
        chk("wb_valid", wb_valid, 64'(ne | m_dv));
        if (ne | m_dv) begin
            chk("wb_src", wb_src, 64'(!sf));
            chk("wb_y", wb_y, e[PW-1 -: 64]);
            chk("wb_rob_ptr", wb_rob_ptr, 64'(e[HW+1 +: RW]));
            chk("wb_hilo_val", wb_hilo_val, 64'(e[HW]));
            chk("wb_hilo_ptr", wb_hilo_ptr, 64'(e[HW-1:0]));
        end
        chk("err", err, 64'(m_err));
        chk("div_ready", div_ready, 64'(!m_dv));
        chk("mul_can_issue", mul_can_issue, 64'((mq.size() + m_infl) < D));
    endtask

    task automatic model_step();
        bit ne, sf, deq, fd, dd, full, old_dv;
        if (reset) begin
            mq.delete();
            m_dv = 0; m_starve = 0; m_infl = 0; m_err = 0;
        end else begin
            ne     = (mq.size() > 0);
            sf     = ne && (!m_dv || m_starve < SL);
            deq    = (ne | m_dv) & wb_ready;
            fd     = deq & sf;
            dd     = deq & !sf;
            full   = (mq.size() == D);
            old_dv = m_dv;
            if (fd) void'(mq.pop_front());
            if (mul_complete) begin
                if (!full || fd) mq.push_back({mul_y, mul_rob_ptr, mul_hilo_val, mul_hilo_ptr});
                else m_err = 1;
            end
            if (dd) m_dv = 0;
            if (div_complete) begin
                if (!old_dv || dd) begin
                    m_div = {div_y, div_rob_ptr, 1'b1, div_hilo_ptr};
                    m_dv  = 1;
                end else m_err = 1;
            end
            if (dd) m_starve = 0;
            else if (old_dv && fd && m_starve < SL) m_starve++;
            if (mul_issue && !mul_complete && m_infl < 2*D-1) m_infl++;
            else if (mul_complete && !mul_issue && m_infl > 0) m_infl--;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_outputs();
        model_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1; mul_issue = 0; mul_complete = 0; mul_hilo_val = 0; div_complete = 0;
        wb_ready = 0; mul_y = '0; div_y = '0; mul_rob_ptr = '0; div_rob_ptr = '0;
        mul_hilo_ptr = '0; div_hilo_ptr = '0;
        m_dv = 0; m_starve = 0; m_infl = 0; m_err = 0; m_div = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        chk("rst_wb_valid", wb_valid, 64'd0);
        chk("rst_div_ready", div_ready, 64'd1);
        chk("rst_can_issue", mul_can_issue, 64'd1);
        chk("rst_err", err, 64'd0);

        // Single multiply
        mul_issue = 1; tick();
        mul_issue = 0; mul_complete = 1; mul_y = 64'h0000_0001_FFFF_FFFE;
        mul_rob_ptr = 5; mul_hilo_val = 1; mul_hilo_ptr = 2; wb_ready = 1;
        chk("single_not_bypassed", wb_valid, 64'd0);
        tick();
        mul_complete = 0;
        chk("single_valid", wb_valid, 64'd1);
        chk("single_y", wb_y, 64'h0000_0001_FFFF_FFFE);
        chk("single_src", wb_src, 64'd0);
        chk("single_rob", wb_rob_ptr, 64'd5);
        tick();
        chk("single_empty_after", wb_valid, 64'd0);

        // Credit limit then in-order drain
        wb_ready = 0;
        for (int i = 0; i < D; i++) begin mul_issue = 1; tick(); end
        mul_issue = 0;
        chk("credit_exhausted", mul_can_issue, 64'd0);
        for (int i = 0; i < D; i++) begin
            mul_complete = 1; mul_y = 64'h100 + 64'(i); mul_rob_ptr = RW'(i); tick();
        end
        mul_complete = 0;
        chk("credit_no_err", err, 64'd0);
        wb_ready = 1;
        for (int i = 0; i < D; i++) begin chk("credit_order", wb_y, 64'h100 + 64'(i)); tick(); end
        chk("credit_drained", wb_valid, 64'd0);

        // Starvation guard
        wb_ready = 0; div_complete = 1; div_y = 64'hD1D1_0000_0000_D1D1;
        div_rob_ptr = 9; div_hilo_ptr = 3; tick();
        div_complete = 0; mul_complete = 1;
        for (int i = 0; i < 2; i++) begin mul_y = 64'h200 + 64'(i); tick(); end
        wb_ready = 1;
        for (int i = 0; i <= SL; i++) begin
            mul_y = 64'h300 + 64'(i);
            chk("starve_src", wb_src, 64'(i == SL));
            tick();
        end
        mul_complete = 0;
        chk("starve_cleared", wb_src, 64'd0);
        repeat (5) tick();

        // Full FIFO with simultaneous enqueue/dequeue, then overflow
        wb_ready = 0; mul_complete = 1;
        for (int i = 0; i < D; i++) begin mul_y = 64'h400 + 64'(i); tick(); end
        wb_ready = 1; mul_y = 64'h4FF; tick();
        chk("full_swap_no_err", err, 64'd0);
        chk("full_swap_head", wb_y, 64'h401);
        wb_ready = 0; mul_y = 64'h4EE; tick();
        mul_complete = 0;
        chk("overflow_err", err, 64'd1);
        tick();
        chk("overflow_err_sticky", err, 64'd1);
        wb_ready = 1;
        repeat (5) tick();

        // Divider overwrite rules
        reset = 1; tick(); reset = 0;
        wb_ready = 0; div_complete = 1; div_y = 64'hA; div_rob_ptr = 1; tick();
        div_y = 64'hB; div_rob_ptr = 2; tick();
        chk("div_overrun_err", err, 64'd1);
        chk("div_held_kept", wb_y, 64'hA);
        wb_ready = 1; div_y = 64'hC; div_rob_ptr = 3; tick();
        div_complete = 0; wb_ready = 0;
        chk("div_replaced", wb_y, 64'hC);
        chk("div_busy", div_ready, 64'd0);
        wb_ready = 1; tick();
        chk("div_freed", div_ready, 64'd1);

        // Reset mid-stream, with inputs active during reset
        reset = 1; tick(); reset = 0; wb_ready = 0;
        mul_complete = 1;
        for (int i = 0; i < 3; i++) begin mul_y = 64'h500 + 64'(i); tick(); end
        mul_complete = 0; mul_issue = 1; div_complete = 1; div_y = 64'hE; tick();
        div_complete = 0; tick();
        mul_issue = 0;
        chk("pre_reset_busy", div_ready, 64'd0);
        reset = 1; mul_issue = 1; mul_complete = 1; div_complete = 1; tick();
        reset = 0; mul_issue = 0; mul_complete = 0; div_complete = 0;
        chk("midrst_wb_valid", wb_valid, 64'd0);
        chk("midrst_can_issue", mul_can_issue, 64'd1);
        chk("midrst_div_ready", div_ready, 64'd1);
        chk("midrst_err", err, 64'd0);
        repeat (2) tick();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            reset        = ($urandom_range(63) == 0);
            mul_issue    = $urandom_range(1);
            mul_complete = ($urandom_range(2) != 0);
            mul_y        = {$urandom, $urandom};
            mul_rob_ptr  = RW'($urandom);
            mul_hilo_val = $urandom_range(1);
            mul_hilo_ptr = HW'($urandom);
            div_complete = ($urandom_range(4) == 0);
            div_y        = {$urandom, $urandom};
            div_rob_ptr  = RW'($urandom);
            div_hilo_ptr = HW'($urandom);
            wb_ready     = ($urandom_range(3) != 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
